m_proc_multicycle: RTL and testbench

//  Multicycle MIPS-subset core: one instruction at a time through IF/ID/EX/MEM/WB states, per-class latency.

---
 rtl/m_proc_multicycle.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_m_proc_multicycle.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_proc_multicycle.sv
// ---------------------------------------------------------------------------
// m_proc_multicycle
//   Multicycle MIPS-subset core. One instruction is in flight at a time and
//   walks IF -> ID -> EX -> {MEM, WB, IF}; HALT is absorbing until reset.
//   Instruction and data memories live outside the core (combinational read,
//   synchronous write), so the same core serves simulation tops and boards.
//
//   Supported: add sub and or slt sllv srlv (R-type), addi, lw, sw, beq, bne,
//   j, halt (op 6'h3f). Anything else halts with w_illegal set.
//
// Ports
//   w_clk          clock, all state on the rising edge
//   w_rst          synchronous active-high reset
//   w_imem_addr    instruction word address (pc[IMEM_AW+1:2])
//   w_imem_data    instruction word for w_imem_addr
//   w_dmem_addr    data word address (ea[DMEM_AW+1:2])
//   w_dmem_we      data write enable, high only in MEM of sw
//   w_dmem_wdata   store data (rt value latched in ID)
//   w_dmem_rdata   load data for w_dmem_addr
//   r_led          mirror of the last value written to register LED_REG
//   w_retire       one-cycle pulse in the final state of each instruction
//   w_halt         sticky: halt or illegal instruction reached
//   w_illegal      sticky: the halt was caused by an unrecognised encoding
// ---------------------------------------------------------------------------
module m_proc_multicycle #(
    parameter int          IMEM_AW  = 11,
    parameter int          DMEM_AW  = 11,
    parameter int          LED_REG  = 30,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               w_clk,
    input  logic               w_rst,
    output logic [IMEM_AW-1:0] w_imem_addr,
    input  logic [31:0]        w_imem_data,
    output logic [DMEM_AW-1:0] w_dmem_addr,
    output logic               w_dmem_we,
    output logic [31:0]        w_dmem_wdata,
    input  logic [31:0]        w_dmem_rdata,
    output logic [31:0]        r_led,
    output logic               w_retire,
    output logic               w_halt,
    output logic               w_illegal
);

    localparam logic [4:0] LED_IDX = LED_REG[4:0];

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_BNE, C_J
    } iclass_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLLV, OP_SRLV
    } aluop_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg;
    logic [31:0] a_reg, b_reg, imm_reg;
    logic [31:0] alu_reg, mdr_reg;
    iclass_t     class_reg;
    aluop_t      aluop_reg;
    logic [4:0]  dest_reg;
    logic        illegal_reg;
    logic [31:0] led_reg;

    // Register file: no reset so it maps onto RAM; r0 handled on the read side.
    logic [31:0] rf [0:31];

    // -----------------------------------------------------------------------
    // Decode (from the latched instruction, used during ID)
    // -----------------------------------------------------------------------
    logic [5:0]  ir_op, ir_funct;
    logic [4:0]  ir_rs, ir_rt, ir_rd;
    logic        dec_valid, dec_halt;
    iclass_t     dec_class;
    aluop_t      dec_aluop;
    logic [4:0]  dec_dest;

    assign ir_op    = ir_reg[31:26];
    assign ir_rs    = ir_reg[25:21];
    assign ir_rt    = ir_reg[20:16];
    assign ir_rd    = ir_reg[15:11];
    assign ir_funct = ir_reg[5:0];

    always_comb begin
        dec_valid = 1'b1;
        dec_halt  = 1'b0;
        dec_class = C_ALU_I;
        dec_aluop = OP_ADD;
        dec_dest  = ir_rt;
        case (ir_op)
            6'h00: begin
                dec_class = C_ALU_R;
                dec_dest  = ir_rd;
                case (ir_funct)
                    6'h20:   dec_aluop = OP_ADD;
                    6'h22:   dec_aluop = OP_SUB;
                    6'h24:   dec_aluop = OP_AND;
                    6'h25:   dec_aluop = OP_OR;
                    6'h2a:   dec_aluop = OP_SLT;
                    6'h04:   dec_aluop = OP_SLLV;
                    6'h06:   dec_aluop = OP_SRLV;
                    default: dec_valid = 1'b0;
                endcase
            end
            6'h08:   dec_class = C_ALU_I;
            6'h23:   dec_class = C_LW;
            6'h2b:   dec_class = C_SW;
            6'h04:   dec_class = C_BEQ;
            6'h05:   dec_class = C_BNE;
            6'h02:   dec_class = C_J;
            6'h3f:   dec_halt  = 1'b1;
            default: dec_valid = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Execute
    // -----------------------------------------------------------------------
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        br_taken;

    assign op_b      = (class_reg == C_ALU_R) ? b_reg : imm_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign br_target = pc_plus4 + {imm_reg[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
    assign br_taken  = (class_reg == C_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

    // Shifts follow MIPS operand order: value is rt (b), amount is rs[4:0] (a).
    always_comb begin
        alu_res = 32'd0;
        case (aluop_reg)
            OP_ADD:  alu_res = a_reg + op_b;
            OP_SUB:  alu_res = a_reg - op_b;
            OP_AND:  alu_res = a_reg & op_b;
            OP_OR:   alu_res = a_reg | op_b;
            OP_SLT:  alu_res = {31'd0, ($signed(a_reg) < $signed(op_b))};
            OP_SLLV: alu_res = b_reg << a_reg[4:0];
            OP_SRLV: alu_res = b_reg >> a_reg[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM: next state, pc update and strobes
    // -----------------------------------------------------------------------
    logic        retire_c;
    logic        store_c;
    logic        wb_c;
    logic        rf_we;
    logic [31:0] wb_val;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        retire_c   = 1'b0;
        store_c    = 1'b0;
        wb_c       = 1'b0;
        case (state_reg)
            S_IF: state_next = S_ID;
            S_ID: begin
                if (dec_halt || !dec_valid) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EX;
                end
            end
            S_EX: begin
                case (class_reg)
                    C_BEQ, C_BNE: begin
                        retire_c   = 1'b1;
                        pc_next    = br_taken ? br_target : pc_plus4;
                        state_next = S_IF;
                    end
                    C_J: begin
                        retire_c   = 1'b1;
                        pc_next    = j_target;
                        state_next = S_IF;
                    end
                    C_LW, C_SW: state_next = S_MEM;
                    default:    state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (class_reg == C_SW) begin
                    store_c    = 1'b1;
                    retire_c   = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = S_IF;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                wb_c       = 1'b1;
                retire_c   = 1'b1;
                pc_next    = pc_plus4;
                state_next = S_IF;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    // Reset wins over any pending store, write-back or retire in the same cycle.
    assign w_dmem_we = store_c & ~w_rst;
    assign w_retire  = retire_c & ~w_rst;
    assign rf_we     = wb_c & ~w_rst & (dest_reg != 5'd0);
    assign wb_val    = (class_reg == C_LW) ? mdr_reg : alu_reg;

    always_ff @(posedge w_clk) begin
        if (rf_we) begin
            rf[dest_reg] <= wb_val;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_reg   <= S_IF;
            pc_reg      <= RESET_PC;
            ir_reg      <= 32'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            imm_reg     <= 32'd0;
            alu_reg     <= 32'd0;
            mdr_reg     <= 32'd0;
            class_reg   <= C_ALU_R;
            aluop_reg   <= OP_ADD;
            dest_reg    <= 5'd0;
            illegal_reg <= 1'b0;
            led_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            case (state_reg)
                S_IF: ir_reg <= w_imem_data;
                S_ID: begin
                    a_reg     <= (ir_rs == 5'd0) ? 32'd0 : rf[ir_rs];
                    b_reg     <= (ir_rt == 5'd0) ? 32'd0 : rf[ir_rt];
                    imm_reg   <= {{16{ir_reg[15]}}, ir_reg[15:0]};
                    class_reg <= dec_class;
                    aluop_reg <= dec_aluop;
                    dest_reg  <= dec_dest;
                    if (!dec_valid) begin
                        illegal_reg <= 1'b1;
                    end
                end
                S_EX:  alu_reg <= alu_res;
                S_MEM: mdr_reg <= w_dmem_rdata;
                default: ;
            endcase
            // The LED mirror commits in the same edge as the regfile write.
            if (rf_we && (dest_reg == LED_IDX)) begin
                led_reg <= wb_val;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign w_imem_addr  = pc_reg[IMEM_AW+1:2];
    assign w_dmem_addr  = alu_reg[DMEM_AW+1:2];
    assign w_dmem_wdata = b_reg;
    assign r_led        = led_reg;
    assign w_halt       = (state_reg == S_HALT);
    assign w_illegal    = illegal_reg;

    // Shamt field has no meaning for the supported R-type ops.
    logic unused_shamt;
    assign unused_shamt = ^ir_reg[10:6];

endmodule

// File: tb/tb_m_proc_multicycle.sv
// ---------------------------------------------------------------------------
// tb_m_proc_multicycle
//   Directed programs for m_proc_multicycle. For each program the expected
//   retire latency and LED value after each retire are queued while the
//   program is loaded; the run loop pops one entry per w_retire pulse.
// ---------------------------------------------------------------------------
module tb_m_proc_multicycle;

    localparam int AW = 11;
    localparam logic [31:0] HALT_I = 32'hfc000000;

    logic           w_clk = 1'b0;
    logic           w_rst = 1'b1;
    logic [AW-1:0]  w_imem_addr;
    logic [31:0]    w_imem_data;
    logic [AW-1:0]  w_dmem_addr;
    logic           w_dmem_we;
    logic [31:0]    w_dmem_wdata;
    logic [31:0]    w_dmem_rdata;
    logic [31:0]    r_led;
    logic           w_retire;
    logic           w_halt;
    logic           w_illegal;

    logic [31:0] imem [0:(1<<AW)-1];
    logic [31:0] dmem [0:(1<<AW)-1];

    always #5 w_clk = ~w_clk;

    assign w_imem_data  = imem[w_imem_addr];
    assign w_dmem_rdata = dmem[w_dmem_addr];

    always @(posedge w_clk) begin
        if (w_dmem_we) dmem[w_dmem_addr] <= w_dmem_wdata;
    end

    m_proc_multicycle #(
        .IMEM_AW (AW),
        .DMEM_AW (AW),
        .LED_REG (30),
        .RESET_PC(32'h0)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_imem_addr (w_imem_addr),
        .w_imem_data (w_imem_data),
        .w_dmem_addr (w_dmem_addr),
        .w_dmem_we   (w_dmem_we),
        .w_dmem_wdata(w_dmem_wdata),
        .w_dmem_rdata(w_dmem_rdata),
        .r_led       (r_led),
        .w_retire    (w_retire),
        .w_halt      (w_halt),
        .w_illegal   (w_illegal)
    );

    typedef struct {
        int          lat;
        logic [31:0] led;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          pa;
    int          we_cnt;
    logic [31:0] we_first, we_last;
    string       prog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", prog, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int idx);
        return {6'h02, idx[25:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < (1 << AW); i++) imem[i] = HALT_I;
        pa = 0;
        sb_q.delete();
    endtask

    // Place an instruction and queue the retire it should produce.
    task automatic put(input logic [31:0] ins, input int lat, input logic [31:0] led);
        imem[pa] = ins;
        pa++;
        if (lat > 0) sb_q.push_back('{lat, led});
    endtask

    task automatic put_halt(input logic [31:0] ins);
        imem[pa] = ins;
        pa++;
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst = 1'b1;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst_pc",      {21'd0, w_imem_addr}, 32'd0);
        chk("rst_led",     r_led, 32'd0);
        chk("rst_halt",    {31'd0, w_halt}, 32'd0);
        chk("rst_illegal", {31'd0, w_illegal}, 32'd0);
        chk("rst_we",      {31'd0, w_dmem_we}, 32'd0);
        chk("rst_retire",  {31'd0, w_retire}, 32'd0);
        w_rst = 1'b0;
    endtask

    // Reset, run until halt (bounded), checking each retire against the queue.
    task automatic run(input int max_cyc, input logic exp_ill, input int exp_addr);
        int          cyc;
        int          last;
        bit          led_pend;
        logic [31:0] led_exp;
        exp_t        e;
        we_cnt   = 0;
        we_first = '0;
        we_last  = '0;
        led_pend = 1'b0;
        led_exp  = '0;
        do_reset();
        cyc  = 1;
        last = 0;
        while (!w_halt && cyc < max_cyc) begin
            @(negedge w_clk);
            cyc++;
            if (led_pend) begin
                chk("led", r_led, led_exp);
                led_pend = 1'b0;
            end
            if (w_retire) begin
                if (sb_q.size() == 0) begin
                    chk("extra_retire_at_cycle", cyc, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", cyc - last, e.lat);
                    $display("retire cycle=%0d lat=%0d pc_word=%0d", cyc, cyc - last, w_imem_addr);
                    last     = cyc;
                    led_pend = 1'b1;
                    led_exp  = e.led;
                end
            end
            if (w_dmem_we) begin
                if (we_cnt == 0) we_first = {21'd0, w_dmem_addr};
                we_last = {21'd0, w_dmem_addr};
                we_cnt++;
            end
        end
        chk("halt",     {31'd0, w_halt}, 32'd1);
        chk("pending",  sb_q.size(), 32'd0);
        chk("illegal",  {31'd0, w_illegal}, {31'd0, exp_ill});
        chk("halt_pc",  {21'd0, w_imem_addr}, exp_addr);
        for (int k = 0; k < 3; k++) begin
            @(negedge w_clk);
            chk("halt_noretire", {31'd0, w_retire}, 32'd0);
            chk("halt_frozen",   {21'd0, w_imem_addr}, exp_addr);
        end
        sb_q.delete();
    endtask

    initial begin
        int cyc;
        logic [31:0] saved;

        // 1: addi to LED register, then halt; pc stays at the halt address.
        prog = "p1";
        clear_imem();
        put(enc_i(6'h08, 0, 30, 5), 4, 32'd5);
        put_halt(HALT_I);
        run(100, 1'b0, 1);

        // 2: ALU ops, signed slt, logical srlv, r0 writes dropped.
        prog = "p2";
        clear_imem();
        put(enc_i(6'h08, 0, 1, -1),  4, 32'd0);
        put(enc_i(6'h08, 0, 3, 28),  4, 32'd0);
        put(enc_r(2, 3, 1, 6'h06),   4, 32'd0);
        put(enc_r(30, 2, 0, 6'h20),  4, 32'h0000000f);
        put(enc_r(4, 1, 0, 6'h2a),   4, 32'h0000000f);
        put(enc_r(30, 4, 0, 6'h20),  4, 32'h00000001);
        put(enc_r(30, 3, 1, 6'h04),  4, 32'hf0000000);
        put(enc_r(30, 30, 2, 6'h25), 4, 32'hf000000f);
        put(enc_r(30, 1, 2, 6'h24),  4, 32'h0000000f);
        put(enc_r(30, 2, 1, 6'h22),  4, 32'h00000010);
        put(enc_r(30, 2, 1, 6'h2a),  4, 32'h00000000);
        put(enc_i(6'h08, 0, 30, 51), 4, 32'h00000033);
        put(enc_i(6'h08, 0, 0, 7),   4, 32'h00000033);
        put(enc_r(30, 0, 0, 6'h20),  4, 32'h00000000);
        put_halt(HALT_I);
        run(200, 1'b0, pa - 1);

        // 3: build 0xdeadbeef, store/load round trip, negative offset load.
        prog = "p3";
        clear_imem();
        put(enc_i(6'h08, 0, 1, 16'hdeae), 4, 32'd0);
        put(enc_i(6'h08, 0, 3, 16),       4, 32'd0);
        put(enc_r(1, 3, 1, 6'h04),        4, 32'd0);
        put(enc_i(6'h08, 1, 1, 16'hbeef), 4, 32'd0);
        put(enc_i(6'h2b, 0, 1, 8),        4, 32'd0);
        put(enc_i(6'h23, 0, 30, 8),       5, 32'hdeadbeef);
        put(enc_i(6'h08, 0, 7, 16),       4, 32'hdeadbeef);
        put(enc_i(6'h2b, 0, 7, 12),       4, 32'hdeadbeef);
        put(enc_i(6'h23, 7, 30, -4),      5, 32'h00000010);
        put_halt(HALT_I);
        run(200, 1'b0, pa - 1);
        chk("we_cycles",  we_cnt, 32'd2);
        chk("we_addr0",   we_first, 32'd2);
        chk("we_addr1",   we_last, 32'd3);
        chk("dmem2",      dmem[2], 32'hdeadbeef);
        chk("dmem3",      dmem[3], 32'h00000010);

        // 4: counted loop with bne, taken beq, untaken beq, j to index 0x10.
        prog = "p4";
        clear_imem();
        put(enc_i(6'h08, 0, 6, 3),  4, 32'd0);
        put(enc_i(6'h08, 0, 5, 0),  4, 32'd0);
        put(enc_i(6'h08, 5, 5, 1),  0, 32'd0);
        put(enc_i(6'h05, 5, 6, -2), 0, 32'd0);
        for (int it = 0; it < 3; it++) begin
            sb_q.push_back('{4, 32'd0});
            sb_q.push_back('{3, 32'd0});
        end
        put(enc_r(30, 5, 0, 6'h20), 4, 32'd3);
        put(enc_i(6'h04, 0, 0, 1),  3, 32'd3);
        put_halt(enc_i(6'h08, 0, 30, 99));
        put(enc_j(16),              3, 32'd3);
        pa = 16;
        put(enc_i(6'h04, 5, 0, 5),  3, 32'd3);
        put(enc_i(6'h08, 0, 30, 64), 4, 32'h40);
        put_halt(HALT_I);
        run(300, 1'b0, 18);

        // 5: unrecognised opcode halts with illegal; a 1-cycle reset clears it.
        prog = "p5";
        clear_imem();
        put(enc_i(6'h08, 0, 30, 7), 4, 32'd7);
        put(enc_i(6'h08, 0, 30, 8), 4, 32'd8);
        put_halt({6'h3e, 26'd0});
        run(100, 1'b1, 2);
        @(negedge w_clk);
        w_rst = 1'b1;
        @(negedge w_clk);
        chk("rst1_halt",    {31'd0, w_halt}, 32'd0);
        chk("rst1_illegal", {31'd0, w_illegal}, 32'd0);
        chk("rst1_pc",      {21'd0, w_imem_addr}, 32'd0);
        w_rst = 1'b0;

        // 5b: unsupported R-type funct is illegal as well.
        prog = "p5b";
        clear_imem();
        put_halt(enc_r(30, 0, 0, 6'h21));
        run(100, 1'b1, 0);

        // 6: reset during MEM of sw discards the store.
        prog = "p6";
        clear_imem();
        put(enc_i(6'h08, 0, 30, 1), 0, 32'd0);
        put(enc_i(6'h08, 0, 1, 9),  0, 32'd0);
        put(enc_i(6'h2b, 0, 1, 8),  0, 32'd0);
        put_halt(HALT_I);
        do_reset();
        cyc = 1;
        while (cyc < 12) begin
            @(negedge w_clk);
            cyc++;
        end
        saved = dmem[2];
        chk("mem_we_before", {31'd0, w_dmem_we}, 32'd1);
        chk("mem_addr",      {21'd0, w_dmem_addr}, 32'd2);
        chk("led_before",    r_led, 32'd1);
        w_rst = 1'b1;
        #1;
        chk("we_under_rst",  {31'd0, w_dmem_we}, 32'd0);
        @(negedge w_clk);
        chk("after_rst_pc",  {21'd0, w_imem_addr}, 32'd0);
        chk("after_rst_led", r_led, 32'd0);
        chk("after_rst_ret", {31'd0, w_retire}, 32'd0);
        chk("dmem_kept",     dmem[2], saved);
        chk("dmem_value",    dmem[2], 32'hdeadbeef);
        w_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge w_clk);
            chk("no_store_restart", {31'd0, w_dmem_we}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
